// File: rtl/div_seq_32.sv
// Iterative unsigned restoring divider: one quotient bit per clock.
// A start/busy/done handshake launches one divide and returns the quotient and remainder.
module div_seq_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;

    logic             sh_top;
    logic             borrow;
    logic             fits;
    logic [WIDTH-1:0] sh_low;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // Trial subtract of the shifted remainder. The bit shifted out of rem acts as
    // the top bit of the WIDTH+1-bit partial remainder: when set, the trial always fits.
    always_comb begin
        sh_top          = rem[WIDTH-1];
        sh_low          = {rem[WIDTH-2:0], quo[WIDTH-1]};
        {borrow, diff}  = {1'b0, sh_low} - {1'b0, dvs};
        fits            = sh_top | ~borrow;
        rem_nx          = fits ? diff : sh_low;
        quo_nx          = {quo[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            Q        <= '0;
            R        <= '0;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (Y != '0) begin
                            quo   <= X;
                            dvs   <= Y;
                            rem   <= '0;
                            cnt   <= CNT_W'(WIDTH);
                            state <= RUN;
                        end else begin
                            // Divide by zero skips the iterations entirely
                            Q        <= '1;
                            R        <= X;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= FIN;
                        end
                    end
                end
                RUN: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        Q        <= quo_nx;
                        R        <= rem_nx;
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        state    <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_32.sv
// Directed bench for div_seq_32: handshake timing, edge-case results, ignored starts,
// mid-operation reset and a small quotient/remainder sweep.
module tb_div_seq_32;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_zero;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    div_seq_32 #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .X        (x),
        .Y        (y),
        .busy     (busy),
        .done     (done),
        .Q        (q),
        .R        (r),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    // Count every cycle in which done is high
    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch one divide, then count edges after the accepting edge until done is seen.
    // Accept at edge t; done is visible in cycle t+1 for Y==0 (0 extra edges) and in
    // cycle t+WIDTH+1 otherwise (WIDTH extra edges).
    task automatic do_div(input logic [WIDTH-1:0] dx, input logic [WIDTH-1:0] dy,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic edz, input string tag);
        int n;
        int lat;
        lat = (dy == '0) ? 0 : WIDTH;
        @(negedge clk);
        start = 1'b1;
        x     = dx;
        y     = dy;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_after_start"}, 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(lat));
        check({tag, ".Q"}, 64'(q), 64'(eq));
        check({tag, ".R"}, 64'(r), 64'(er));
        check({tag, ".div_zero"}, 64'(div_zero), 64'(edz));
        @(posedge clk);
        #1;
        check({tag, ".done_low_after"}, 64'(done), 64'd0);
        check({tag, ".busy_low_after"}, 64'(busy), 64'd0);
        check({tag, ".Q_hold"}, 64'(q), 64'(eq));
    endtask

    initial begin
        int n;
        int dc;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.Q", 64'(q), 64'd0);
        check("rst.R", 64'(r), 64'd0);
        check("rst.div_zero", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "d100_7");
        do_div(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, "lt");
        do_div(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, "y1");
        do_div(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, "eq");
        do_div(32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, "dz");
        do_div(32'd10, 32'd3, 32'd3, 32'd1, 1'b0, "after_dz");

        // Starts during RUN and during FIN must be ignored
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        x     = 32'd1000;
        y     = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (n == 4) begin
                start = 1'b1;
                x     = 32'd9;
                y     = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        check("ign.latency", 64'(n), 64'(WIDTH));
        check("ign.Q", 64'(q), 64'd100);
        check("ign.R", 64'(r), 64'd0);
        start = 1'b1;
        x     = 32'd9;
        y     = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign.busy_after_fin", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("ign.done_pulses", 64'(done_cnt - dc), 64'd1);
        check("ign.Q_final", 64'(q), 64'd100);

        // Reset in the middle of an operation discards it silently
        dc = done_cnt;
        @(negedge clk);
        start = 1'b1;
        x     = 32'd50;
        y     = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst.busy", 64'(busy), 64'd0);
        check("mrst.Q", 64'(q), 64'd0);
        check("mrst.R", 64'(r), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("mrst.no_done", 64'(done_cnt - dc), 64'd0);
        do_div(32'd50, 32'd4, 32'd12, 32'd2, 1'b0, "post_rst");

        for (int j = 0; j < 100; j++) begin
            do_div(WIDTH'(j), WIDTH'(j + 1), 32'd0, WIDTH'(j), 1'b0, "sweep_lt");
            do_div(WIDTH'(15 + j), 32'd3, WIDTH'((15 + j) / 3), WIDTH'((15 + j) % 3),
                   1'b0, "sweep_d3");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_seq_32.md
Name: div_seq_32

Overview:
- Iterative unsigned restoring divider: one quotient bit per clock, built on a WIDTH-bit subtract/compare datapath.
- It is the inverse-operation companion to the team's CLA adder family and is used where a multi-cycle divide is acceptable.
- A start/busy/done handshake lets a controller launch one divide and collect quotient and remainder.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (supported range 2..64).
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter. This is derived and must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, active-low, synchronous (sampled on rising clk edge)
- start  input  1  request a divide; sampled only in IDLE
- X  input  WIDTH  dividend; captured on the accepted start
- Y  input  WIDTH  divisor; captured on the accepted start
- busy  output  1  high from the cycle after an accepted start until done is deasserted
- done  output  1  one-cycle pulse; Q, R and div_zero are valid from this cycle on
- Q  output  WIDTH  quotient
- R  output  WIDTH  remainder
- div_zero  output  1  last completed operation had Y==0

Behaviour:
- Reset: when rst_n==0 at a clk edge:
  - state goes to IDLE.
  - busy, done, div_zero, Q, R and the iteration counter go to 0.
  - Reset overrides everything, including an operation in progress, which is discarded silently with no done pulse.
- States: IDLE, RUN, FIN.
- IDLE:
  - start==1 and Y!=0: latch X into the quotient/shift register, Y into the divisor register, clear the partial remainder, load counter=WIDTH, go to RUN.
  - start==1 and Y==0: go straight to FIN with div_zero pending.
  - start==0: stay in IDLE.
- RUN, once per cycle:
  - shift {rem, quo} left by 1.
  - trial = rem_shifted - divisor, computed at WIDTH+1 bits.
  - trial non-negative: rem = trial, quo[0] = 1. Negative: rem is kept, quo[0] = 0.
  - Decrement the counter. When the counter reaches 0 after the WIDTH-th iteration, go to FIN.
- FIN:
  - done=1 for exactly one cycle; Q and R are registered with the results; go to IDLE.
  - For Y==0: Q = all ones, R = X, div_zero = 1.
  - Otherwise div_zero = 0.
- busy: 1 in RUN and FIN, 0 in IDLE.
- Latency, accepted start at edge t (Y!=0):
  - WIDTH RUN cycles, FIN in cycle t+WIDTH+1, so done is high during cycle WIDTH+1 after acceptance (33 for WIDTH=32).
  - Y==0: done in cycle t+1.
- start while busy (RUN or FIN) is ignored; X and Y are not re-sampled.
- start asserted in the cycle after done (IDLE again) is accepted normally. Back-to-back throughput is one op per WIDTH+2 cycles.
- Q, R and div_zero hold their last values in IDLE and RUN. They change only in FIN or on reset.
- No signed support. Arithmetic is strictly unsigned. Remainder is always < Y when Y != 0.
- Edge cases:
  - X < Y gives Q=0, R=X.
  - X == Y gives Q=1, R=0.
  - Y == 1 gives Q=X, R=0.

Test Plan:
- Reset, then start with X=100, Y=7 → busy next cycle; done pulses exactly 33 cycles after the accepted edge with Q=14, R=2, div_zero=0; busy low the following cycle.
- X=5, Y=9 → Q=0, R=5. Then X=32'hFFFFFFFF, Y=1 → Q=32'hFFFFFFFF, R=0. Then X=32'hFFFFFFFF, Y=32'hFFFFFFFF → Q=1, R=0.
- X=1234, Y=0 → done one cycle after acceptance with Q=32'hFFFFFFFF, R=1234, div_zero=1. A following 10/3 → Q=3, R=1, div_zero=0.
- Start 1000/10. Pulse start with X=9, Y=2 at cycle 5 and again in the FIN cycle → both ignored; result is Q=100, R=0 with a single done pulse.
- Start 50/4 and drop rst_n for one cycle at cycle 10 → no done pulse; busy=0, Q=0, R=0 after reset. A new 50/4 → Q=12, R=2.
- Sweep j=0..99 with X=j, Y=j+1 and X=15+j, Y=3 → Q and R must match X/Y and X%Y respectively on every done pulse.
